// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side operands and control flowing in, EX-side registered copies flowing out.
// The master modport is the surrounding datapath; the slave modport is the pipeline register.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              id_valid;
   logic [10:0]       id_ctrl;
   logic [DATA_W-1:0] id_pc4;
   logic [DATA_W-1:0] id_rd1;
   logic [DATA_W-1:0] id_rd2;
   logic [DATA_W-1:0] id_imm;
   logic [REG_W-1:0]  id_rs;
   logic [REG_W-1:0]  id_rt;
   logic [REG_W-1:0]  id_rd;
   logic [5:0]        id_funct;

   logic              ex_valid;
   logic [10:0]       ex_ctrl;
   logic [DATA_W-1:0] ex_pc4;
   logic [DATA_W-1:0] ex_rd1;
   logic [DATA_W-1:0] ex_rd2;
   logic [DATA_W-1:0] ex_imm;
   logic [REG_W-1:0]  ex_rs;
   logic [REG_W-1:0]  ex_rt;
   logic [REG_W-1:0]  ex_rd;
   logic [5:0]        ex_funct;

   modport master (
      output id_valid, id_ctrl, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
      input  ex_valid, ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct
   );

   modport slave (
      input  id_valid, id_ctrl, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
      output ex_valid, ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct
   );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS ID/EX pipeline register with load-use hazard detection, flush squashing
// and a saturating stall-cycle counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_stage_if.slave     bus,
   input  logic             flush,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);
   logic              use_rt;
   logic              hazard;

   logic              ex_valid_d, ex_valid_q;
   logic [10:0]       ex_ctrl_d, ex_ctrl_q;
   logic [DATA_W-1:0] ex_pc4_d, ex_pc4_q;
   logic [DATA_W-1:0] ex_rd1_d, ex_rd1_q;
   logic [DATA_W-1:0] ex_rd2_d, ex_rd2_q;
   logic [DATA_W-1:0] ex_imm_d, ex_imm_q;
   logic [REG_W-1:0]  ex_rs_d, ex_rs_q;
   logic [REG_W-1:0]  ex_rt_d, ex_rt_q;
   logic [REG_W-1:0]  ex_rd_d, ex_rd_q;
   logic [5:0]        ex_funct_d, ex_funct_q;
   logic [CNT_W-1:0]  stall_count_d, stall_count_q;

   // rt is a source for R-type and branches (ALU takes rt) and for SW (store data).
   always_comb begin
      use_rt = ~bus.id_ctrl[3] | bus.id_ctrl[6];
      hazard = ex_valid_q & ex_ctrl_q[7] & (ex_rt_q != '0) & bus.id_valid &
               ((ex_rt_q == bus.id_rs) | (use_rt & (ex_rt_q == bus.id_rt)));
      stall  = hazard & ~flush;
   end

   // Flush and stall both produce an all-zero bubble; only a clean capture loads ID state.
   always_comb begin
      ex_valid_d    = 1'b0;
      ex_ctrl_d     = '0;
      ex_pc4_d      = '0;
      ex_rd1_d      = '0;
      ex_rd2_d      = '0;
      ex_imm_d      = '0;
      ex_rs_d       = '0;
      ex_rt_d       = '0;
      ex_rd_d       = '0;
      ex_funct_d    = '0;
      stall_count_d = stall_count_q;
      if (!flush && !stall && bus.id_valid) begin
         ex_valid_d = 1'b1;
         ex_ctrl_d  = bus.id_ctrl;
         ex_pc4_d   = bus.id_pc4;
         ex_rd1_d   = bus.id_rd1;
         ex_rd2_d   = bus.id_rd2;
         ex_imm_d   = bus.id_imm;
         ex_rs_d    = bus.id_rs;
         ex_rt_d    = bus.id_rt;
         ex_rd_d    = bus.id_rd;
         ex_funct_d = bus.id_funct;
      end
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_pc4_q      <= '0;
         ex_rd1_q      <= '0;
         ex_rd2_q      <= '0;
         ex_imm_q      <= '0;
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         ex_rd_q       <= '0;
         ex_funct_q    <= '0;
         stall_count_q <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_pc4_q      <= ex_pc4_d;
         ex_rd1_q      <= ex_rd1_d;
         ex_rd2_q      <= ex_rd2_d;
         ex_imm_q      <= ex_imm_d;
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         ex_rd_q       <= ex_rd_d;
         ex_funct_q    <= ex_funct_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.ex_valid = ex_valid_q;
   assign bus.ex_ctrl  = ex_ctrl_q;
   assign bus.ex_pc4   = ex_pc4_q;
   assign bus.ex_rd1   = ex_rd1_q;
   assign bus.ex_rd2   = ex_rd2_q;
   assign bus.ex_imm   = ex_imm_q;
   assign bus.ex_rs    = ex_rs_q;
   assign bus.ex_rt    = ex_rt_q;
   assign bus.ex_rd    = ex_rd_q;
   assign bus.ex_funct = ex_funct_q;
   assign stall_count  = stall_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, saturation/reset sequences, and
// randomized traffic against a transaction-level reference model.
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam logic [10:0] C_LW   = 11'b10010001000;
   localparam logic [10:0] C_ADD  = 11'b11000010010;
   localparam logic [10:0] C_ADDI = 11'b10000001010;
   localparam logic [10:0] C_SW   = 11'h04A;
   localparam logic [10:0] C_BEQ  = 11'h026;
   localparam logic [10:0] C_J    = 11'h100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          stall;
   logic [CW-1:0] stall_count;

   id_ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();

   id_ex_stage #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .flush       (flush),
      .stall       (stall),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rst_n;
      logic        vld;
      logic [10:0] ctrl;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        fl;
      logic        e_stall;
      logic        e_vld;
      logic [10:0] e_ctrl;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tbl[23];

   // Reference model: the instruction currently sitting in EX, plus the stall tally.
   logic        m_vld;
   logic [10:0] m_ctrl;
   logic [127:0] m_data;
   logic [20:0] m_fld;
   int          m_cnt;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_id(input logic vld, input logic [10:0] ctrl, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc4,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [5:0] funct);
      bus.id_valid = vld;
      bus.id_ctrl  = ctrl;
      bus.id_rs    = rs;
      bus.id_rt    = rt;
      bus.id_rd    = rd;
      bus.id_pc4   = pc4;
      bus.id_rd1   = rd1;
      bus.id_rd2   = rd2;
      bus.id_imm   = imm;
      bus.id_funct = funct;
   endtask

   function automatic logic [127:0] dut_data();
      return {bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm};
   endfunction

   function automatic logic [20:0] dut_fld();
      return {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_funct};
   endfunction

   // A load in EX whose destination (nonzero) is read by the valid ID instruction forces a stall.
   function automatic logic model_stall();
      logic reads_rt;
      logic is_load;
      reads_rt = (bus.id_ctrl[3] == 1'b0) || (bus.id_ctrl[6] == 1'b1);
      is_load  = m_vld && m_ctrl[7] && (m_fld[15:11] != 5'd0);
      if (!is_load || !bus.id_valid || flush) return 1'b0;
      return (m_fld[15:11] == bus.id_rs) || (reads_rt && (m_fld[15:11] == bus.id_rt));
   endfunction

   task automatic model_edge();
      logic s;
      s = model_stall();
      if (!rst_n) begin
         m_cnt = 0;
         s = 1'b1;
      end else if (s) begin
         m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
      if (s || flush || !bus.id_valid) begin
         m_vld  = 1'b0;
         m_ctrl = '0;
         m_data = '0;
         m_fld  = '0;
      end else begin
         m_vld  = 1'b1;
         m_ctrl = bus.id_ctrl;
         m_data = {bus.id_pc4, bus.id_rd1, bus.id_rd2, bus.id_imm};
         m_fld  = {bus.id_rs, bus.id_rt, bus.id_rd, bus.id_funct};
      end
   endtask

   task automatic rcycle(input string tag);
      #2;
      chk({tag, "_stall"}, stall, model_stall());
      model_edge();
      @(posedge clk);
      #1;
      chk({tag, "_vld"}, bus.ex_valid, m_vld);
      chk({tag, "_ctrl"}, bus.ex_ctrl, m_ctrl);
      chk({tag, "_data"}, dut_data(), m_data);
      chk({tag, "_fld"}, dut_fld(), m_fld);
      chk({tag, "_cnt"}, stall_count, m_cnt[CW-1:0]);
   endtask

   initial begin
      // rst_n vld ctrl rs rt flush | stall ex_valid ex_ctrl stall_count
      tbl[0]  = '{1'b0, 1'b1, 11'h50A, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 11'h000, 4'd0};
      tbl[1]  = '{1'b0, 1'b1, 11'h50A, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 11'h000, 4'd0};
      tbl[2]  = '{1'b1, 1'b1, C_ADD,   5'd1, 5'd2, 1'b0, 1'b0, 1'b1, C_ADD,   4'd0};
      tbl[3]  = '{1'b1, 1'b1, C_LW,    5'd1, 5'd8, 1'b0, 1'b0, 1'b1, C_LW,    4'd0};
      tbl[4]  = '{1'b1, 1'b1, C_ADD,   5'd8, 5'd2, 1'b0, 1'b1, 1'b0, 11'h000, 4'd1};
      tbl[5]  = '{1'b1, 1'b1, C_ADD,   5'd8, 5'd2, 1'b0, 1'b0, 1'b1, C_ADD,   4'd1};
      tbl[6]  = '{1'b1, 1'b1, C_LW,    5'd3, 5'd0, 1'b0, 1'b0, 1'b1, C_LW,    4'd1};
      tbl[7]  = '{1'b1, 1'b1, C_ADD,   5'd0, 5'd5, 1'b0, 1'b0, 1'b1, C_ADD,   4'd1};
      tbl[8]  = '{1'b1, 1'b1, C_LW,    5'd2, 5'd9, 1'b0, 1'b0, 1'b1, C_LW,    4'd1};
      tbl[9]  = '{1'b1, 1'b1, C_ADDI,  5'd4, 5'd9, 1'b0, 1'b0, 1'b1, C_ADDI,  4'd1};
      tbl[10] = '{1'b1, 1'b1, C_LW,    5'd2, 5'd9, 1'b0, 1'b0, 1'b1, C_LW,    4'd1};
      tbl[11] = '{1'b1, 1'b1, C_SW,    5'd4, 5'd9, 1'b0, 1'b1, 1'b0, 11'h000, 4'd2};
      tbl[12] = '{1'b1, 1'b1, C_SW,    5'd4, 5'd9, 1'b0, 1'b0, 1'b1, C_SW,    4'd2};
      tbl[13] = '{1'b1, 1'b1, C_LW,    5'd1, 5'd8, 1'b0, 1'b0, 1'b1, C_LW,    4'd2};
      tbl[14] = '{1'b1, 1'b1, C_BEQ,   5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 11'h000, 4'd2};
      tbl[15] = '{1'b1, 1'b0, C_ADD,   5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 11'h000, 4'd2};
      tbl[16] = '{1'b1, 1'b1, C_LW,    5'd1, 5'd8, 1'b0, 1'b0, 1'b1, C_LW,    4'd2};
      tbl[17] = '{1'b1, 1'b1, C_LW,    5'd8, 5'd7, 1'b0, 1'b1, 1'b0, 11'h000, 4'd3};
      tbl[18] = '{1'b1, 1'b1, C_LW,    5'd8, 5'd7, 1'b0, 1'b0, 1'b1, C_LW,    4'd3};
      tbl[19] = '{1'b1, 1'b1, C_ADD,   5'd7, 5'd2, 1'b0, 1'b1, 1'b0, 11'h000, 4'd4};
      tbl[20] = '{1'b1, 1'b1, C_ADD,   5'd7, 5'd2, 1'b0, 1'b0, 1'b1, C_ADD,   4'd4};
      tbl[21] = '{1'b1, 1'b1, C_LW,    5'd1, 5'd6, 1'b0, 1'b0, 1'b1, C_LW,    4'd4};
      tbl[22] = '{1'b1, 1'b0, C_ADD,   5'd6, 5'd2, 1'b0, 1'b0, 1'b0, 11'h000, 4'd4};

      set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
      rst_n = 1'b0;
      flush = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 23; i++) begin
         logic [31:0] pc4, rd1, rd2, imm;
         logic [5:0]  funct;
         pc4   = 32'hFC + 32'(4 * i);
         rd1   = 32'(3 + i);
         rd2   = 32'(5 + i);
         imm   = 32'hFFFF_0000 | 32'(i);
         funct = 6'h1E + 6'(i);
         rst_n = tbl[i].rst_n;
         flush = tbl[i].fl;
         set_id(tbl[i].vld, tbl[i].ctrl, tbl[i].rs, tbl[i].rt, 5'd3, pc4, rd1, rd2, imm, funct);
         #2;
         chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_vld", i), bus.ex_valid, tbl[i].e_vld);
         chk($sformatf("vec%0d_ctrl", i), bus.ex_ctrl, tbl[i].e_ctrl);
         chk($sformatf("vec%0d_cnt", i), stall_count, tbl[i].e_cnt);
         chk($sformatf("vec%0d_data", i), dut_data(),
             tbl[i].e_vld ? {pc4, rd1, rd2, imm} : 128'd0);
         chk($sformatf("vec%0d_fld", i), dut_fld(),
             tbl[i].e_vld ? {tbl[i].rs, tbl[i].rt, 5'd3, funct} : 21'd0);
      end

      // Saturation: 20 load-use pairs drive the 4-bit counter past its ceiling.
      flush = 1'b0;
      rst_n = 1'b0;
      set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
      m_vld = 1'b0; m_ctrl = '0; m_data = '0; m_fld = '0; m_cnt = 0;
      rcycle("sat_rst");
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         set_id(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h200, 32'd1, 32'd2, 32'd4, 6'd0);
         rcycle("sat_lw");
         set_id(1'b1, C_ADD, 5'd8, 5'd2, 5'd3, 32'h204, 32'd5, 32'd6, 32'd0, 6'h20);
         rcycle("sat_add_stall");
         rcycle("sat_add");
      end
      chk("sat_ceiling", stall_count, 4'd15);

      // Reset arriving while a stall is asserted.
      set_id(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h300, 32'd1, 32'd2, 32'd4, 6'd0);
      rcycle("mid_lw");
      set_id(1'b1, C_ADD, 5'd8, 5'd2, 5'd3, 32'h304, 32'd5, 32'd6, 32'd0, 6'h20);
      #2;
      chk("mid_stall_before_rst", stall, 1'b1);
      rst_n = 1'b0;
      rcycle("mid_rst");
      chk("mid_rst_cnt", stall_count, 4'd0);
      rst_n = 1'b1;
      #2;
      chk("mid_rst_stall_drop", stall, 1'b0);
      rcycle("mid_after");

      // Randomized traffic: small register range to make hazards frequent.
      for (int n = 0; n < 400; n++) begin
         logic [10:0] c;
         case ($urandom_range(0, 6))
            0, 1:    c = C_LW;
            2:       c = C_ADD;
            3:       c = C_ADDI;
            4:       c = C_SW;
            5:       c = ($urandom_range(0, 1) != 0) ? C_BEQ : C_J;
            default: c = 11'($urandom);
         endcase
         rst_n = ($urandom_range(0, 24) != 0);
         flush = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom), $urandom, $urandom, $urandom, $urandom, 6'($urandom));
         rcycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX) of the MIPS datapath.
- Captures the control-unit bundle together with the decoded operands and register fields.
- Detects load-use hazards, stalls PC and IF/ID, and inserts a bubble into EX.
- Squashes the ID instruction on a flush request (branch taken or jump) and counts stall cycles for performance monitoring.

Parameters:
- DATA_W, 32, width of PC+4, operand and immediate paths
- REG_W, 5, register-index width
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  11  control bundle: [10]EnWR_BR [9]En_MultiPlexor_br [8]Jump [7]EnWR_R_MemDatos [6]EnWR_w_MemDatos [5]Branch [4]En_MultiPlexor_w [3]En_MultiPlexor_ALU [2:0]ALUC
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rd1  in  DATA_W  register-file read data 1
- id_rd2  in  DATA_W  register-file read data 2
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W each  instruction register fields
- id_funct  in  6  R-type function field
- flush  in  1  squash the ID instruction this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  11  registered control bundle, same bit map as id_ctrl
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered data
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered fields
- ex_funct  out  6  registered funct
- stall  out  1  combinational; freezes PC and IF/ID
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All ex_* outputs become 0, including ex_valid=0 and ex_ctrl=0.
  - stall_count becomes 0.
  - Reset takes priority over every other event; a reset arriving mid-stall clears the state, and stall falls on the next evaluation because ex_valid is now 0.
- Source-use of rt (combinational): use_rt = id_ctrl[3]==0 (R-type, BEQ, BNE) OR id_ctrl[6]==1 (SW).
- Hazard (combinational): hazard = ex_valid & ex_ctrl[7] & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | (use_rt & ex_rt==id_rt)).
- stall = hazard & ~flush. A flushed instruction needs no stall.
- Per-edge update when rst_n=1, in priority order:
  1. flush=1: bubble. ex_valid=0, ex_ctrl=0, all data and field outputs 0.
  2. stall=1: bubble, identical to case 1. Upstream holds the ID instruction, which is re-presented next cycle.
  3. Otherwise: capture. ex_valid<=id_valid, then:
     - If id_valid=1: ex_ctrl<=id_ctrl; data and fields captured.
     - If id_valid=0: ex_ctrl<=0, data and fields <=0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Stall length for a load-use hazard is exactly 1 cycle. The bubble clears ex_ctrl[7], so hazard deasserts on the following cycle.
- Back-to-back loads with a dependency each stall 1 cycle independently.
- Jump (id_ctrl[8]=1) is passed through unchanged. Unused bundle bits for J arrive as 0 from decode. This block never interprets Jump; the redirect logic raises flush.
- stall_count increments by 1 on every edge where stall=1, saturates at all-ones, and is never cleared except by reset.
- No X propagation: every output register is assigned in every branch.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with id_valid=1 and id_ctrl=11'h50A -> ex_valid=0, ex_ctrl=0, stall_count=0, stall=0.
- Capture: ADD (id_ctrl=11'b11000010010), id_pc4=0x104, id_rd1=5, id_rd2=7, rs=1, rt=2, rd=3, funct=0x20 -> one cycle later ex_ctrl=11'b11000010010, ex_rd1=5, ex_rd2=7, ex_rd=3, ex_pc4=0x104, ex_valid=1.
- Load-use: LW with rt=8 (id_ctrl=11'b10010001000), then ADD with rs=8 ->
  - stall=1 for exactly 1 cycle; next ex_valid=0, ex_ctrl=0.
  - ADD captured the cycle after; stall_count=1.
- No false hazard:
  - LW rt=0 followed by ADD rs=0 -> stall=0.
  - LW rt=9 followed by ADDI rt=9 (use_rt=0), rs=4 -> stall=0.
  - LW rt=9 followed by SW rt=9 -> stall=1.
- Flush priority: LW rt=8, then BEQ rs=8 with flush=1 in the same cycle -> stall=0, ex_valid=0, stall_count unchanged.
- Saturation: with CNT_W=4, force 20 consecutive LW/ADD hazard pairs (20 stalls) -> stall_count stops at 15; a reset mid-stall returns stall_count=0 and ex_valid=0.
